// File: rtl/onehot_pulse_decoder_if.sv
// Code handshake plus decoded-line outputs for onehot_pulse_decoder.
interface onehot_pulse_decoder_if;
  logic       e;
  logic       in_valid;
  logic [2:0] in;
  logic       in_ready;
  logic [7:0] out;
  logic       busy;
  logic       done;

  modport master (output e, in_valid, in, input in_ready, out, busy, done);
  modport slave  (input e, in_valid, in, output in_ready, out, busy, done);
endinterface

// File: rtl/onehot_pulse_decoder.sv
// 3-bit code -> one-hot line held HOLD cycles, GAP idle cycles between pulses,
// fed from a 2-entry FIFO.
module onehot_pulse_decoder #(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_pulse_decoder_if.slave bus
);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
  localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t          state, state_n;
  logic [7:0]      cnt, cnt_n;
  logic [7:0]      out_q, out_n;
  logic            done_q, done_n, busy_q;

  logic [1:0][2:0] mem;
  logic            rd_ptr, wr_ptr;
  logic [1:0]      count;
  logic            push, pop, fifo_empty, fifo_full, load;
  logic [2:0]      head;

  assign fifo_full  = (count == 2'd2);
  assign fifo_empty = (count == 2'd0);
  assign head       = mem[rd_ptr];
  assign push       = bus.in_valid && !fifo_full;
  // a pulse may start only when enabled and a code is waiting
  assign load       = bus.e && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!bus.e) state_n = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (load) state_n = S_DRIVE;
        S_DRIVE: if (cnt == 8'd0) begin
          if (GAP > 0)   state_n = S_GAP;
          else if (load) state_n = S_DRIVE;
          else           state_n = S_IDLE;
        end
        S_GAP:   if (cnt == 8'd0) state_n = load ? S_DRIVE : S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pop    = 1'b0;
    cnt_n  = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
    out_n  = out_q;
    done_n = 1'b0;
    if (!bus.e) begin
      // abort: in-flight code is dropped, queued codes stay
      cnt_n = 8'd0;
      out_n = 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_n = 8'd0;
          out_n = 8'd0;
          if (load) begin
            pop   = 1'b1;
            out_n = 8'd1 << head;
            cnt_n = HOLD_M1;
          end
        end
        S_DRIVE: if (cnt == 8'd0) begin
          done_n = 1'b1;
          if (GAP > 0) begin
            out_n = 8'd0;
            cnt_n = GAP_M1;
          end else if (load) begin
            pop   = 1'b1;
            out_n = 8'd1 << head;
            cnt_n = HOLD_M1;
          end else begin
            out_n = 8'd0;
            cnt_n = 8'd0;
          end
        end
        S_GAP: begin
          out_n = 8'd0;
          if (cnt == 8'd0 && load) begin
            pop   = 1'b1;
            out_n = 8'd1 << head;
            cnt_n = HOLD_M1;
          end
        end
        default: begin
          out_n = 8'd0;
          cnt_n = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 8'd0;
      out_q  <= 8'd0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      out_q  <= out_n;
      done_q <= done_n;
      busy_q <= (state_n != S_IDLE);
    end
  end

  assign bus.in_ready = !fifo_full;
  assign bus.out      = out_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Scoreboard bench: codes queued on accept, expected line trace expanded from the queue.
module tb_onehot_pulse_decoder;
  localparam int HOLD = 4;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  onehot_pulse_decoder_if ia();
  onehot_pulse_decoder_if ib();

  onehot_pulse_decoder #(.HOLD(HOLD), .GAP(GAP)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  onehot_pulse_decoder #(.HOLD(HOLD), .GAP(0))   dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  int         tests = 0;
  int         fails = 0;
  logic [2:0] sbq[$];
  logic [7:0] obs      [0:31];
  logic       obs_done [0:31];
  logic [7:0] exp_out  [0:31];
  logic       exp_done [0:31];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // expand queued codes into the expected trace: HOLD cycles high, gap cycles low
  task automatic fill_exp(input int start, input int gap);
    int idx;
    logic [2:0] code;
    for (int i = 0; i < 32; i++) begin
      exp_out[i]  = 8'd0;
      exp_done[i] = 1'b0;
    end
    idx = start;
    while (sbq.size() > 0) begin
      code = sbq.pop_front();
      for (int h = 0; h < HOLD; h++) begin
        if (idx < 32) exp_out[idx] = 8'd1 << code;
        idx++;
      end
      if (idx < 32) exp_done[idx] = 1'b1;
      idx += gap;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.in_valid = 1'b1;
    ia.in = 3'd3;
    tick();
    tick();
    tests++;
    if (ia.out !== 8'd0 || ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_a: out=%h busy=%b done=%b rdy=%b, want 00 0 0 1", ia.out, ia.busy, ia.done, ia.in_ready);
    end
    tests++;
    if (ib.out !== 8'd0 || ib.busy !== 1'b0 || ib.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_b: out=%h busy=%b rdy=%b, want 00 0 1", ib.out, ib.busy, ib.in_ready);
    end
    rst = 1'b0;
    ia.in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests++;
      if (ia.out !== 8'd0 || ia.busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_push_dropped[%0d]: out=%h busy=%b, want 00 0", c, ia.out, ia.busy);
      end
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        ia.in_valid = 1'b1;
        ia.in = 3'd5;
        sbq.push_back(3'd5);
      end else ia.in_valid = 1'b0;
      tick();
      obs[c] = ia.out;
      obs_done[c] = ia.done;
      if (c == 5 || c == 6) begin
        tests++;
        if (ia.busy !== (c == 5)) begin
          fails++;
          $display("FAIL single_busy[%0d]: got %b want %b", c, ia.busy, c == 5);
        end
      end
    end
    fill_exp(1, GAP);
    for (int c = 0; c < 8; c++) begin
      tests++;
      if (obs[c] !== exp_out[c] || obs_done[c] !== exp_done[c]) begin
        fails++;
        $display("FAIL single[%0d]: out=%h done=%b, want %h %b", c, obs[c], obs_done[c], exp_out[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] codes [0:2];
    int k, nd;
    codes[0] = 3'd7; codes[1] = 3'd0; codes[2] = 3'd2;
    k = 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (k < 3 && ia.in_ready) begin
        ia.in_valid = 1'b1;
        ia.in = codes[k];
        sbq.push_back(codes[k]);
        k++;
      end else ia.in_valid = 1'b0;
      tick();
      obs[c] = ia.out;
      obs_done[c] = ia.done;
      if (ia.done) nd++;
      if (c == 2) begin
        tests++;
        if (ia.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL b2b_full_ready: got %b want 0", ia.in_ready);
        end
      end
    end
    tests++;
    if (k != 3) begin
      fails++;
      $display("FAIL b2b_accepted: got %0d want 3", k);
    end
    fill_exp(1, GAP);
    for (int c = 0; c < 20; c++) begin
      tests++;
      if (obs[c] !== exp_out[c] || obs_done[c] !== exp_done[c]) begin
        fails++;
        $display("FAIL b2b[%0d]: out=%h done=%b, want %h %b", c, obs[c], obs_done[c], exp_out[c], exp_done[c]);
      end
    end
    tests++;
    if (nd != 3) begin
      fails++;
      $display("FAIL b2b_done_count: got %0d want 3", nd);
    end
  endtask

  task automatic test_gap0();
    for (int c = 0; c < 12; c++) begin
      if (c < 2) begin
        ib.in_valid = 1'b1;
        ib.in = (c == 0) ? 3'd1 : 3'd6;
        sbq.push_back(ib.in);
      end else ib.in_valid = 1'b0;
      tick();
      obs[c] = ib.out;
      obs_done[c] = ib.done;
    end
    fill_exp(1, 0);
    for (int c = 0; c < 12; c++) begin
      tests++;
      if (obs[c] !== exp_out[c] || obs_done[c] !== exp_done[c]) begin
        fails++;
        $display("FAIL gap0[%0d]: out=%h done=%b, want %h %b", c, obs[c], obs_done[c], exp_out[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_enable_abort();
    for (int c = 0; c < 20; c++) begin
      ia.in_valid = 1'b0;
      if (c == 0 || c == 1 || c == 4) begin
        ia.in_valid = 1'b1;
        ia.in = (c == 0) ? 3'd4 : (c == 1) ? 3'd3 : 3'd6;
        sbq.push_back(ia.in);
      end
      if (c == 3) ia.e = 1'b0;
      if (c == 6) ia.e = 1'b1;
      tick();
      obs[c] = ia.out;
      obs_done[c] = ia.done;
      if (c == 4) begin
        tests++;
        if (ia.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL abort_push_while_off: rdy=%b want 0", ia.in_ready);
        end
      end
    end
    for (int c = 1; c < 3; c++) begin
      tests++;
      if (obs[c] !== 8'h10) begin
        fails++;
        $display("FAIL abort_pre[%0d]: out=%h want 10", c, obs[c]);
      end
    end
    void'(sbq.pop_front());  // aborted in-flight code is gone
    fill_exp(6, GAP);
    for (int c = 3; c < 20; c++) begin
      tests++;
      if (obs[c] !== exp_out[c] || obs_done[c] !== exp_done[c]) begin
        fails++;
        $display("FAIL abort[%0d]: out=%h done=%b, want %h %b", c, obs[c], obs_done[c], exp_out[c], exp_done[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      ia.in_valid = 1'b1;
      ia.in = (c == 0) ? 3'd4 : (c == 1) ? 3'd1 : 3'd2;
      tick();
    end
    ia.in_valid = 1'b0;
    tests++;
    if (ia.out !== 8'h10 || ia.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_pre: out=%h rdy=%b, want 10 0", ia.out, ia.in_ready);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (ia.out !== 8'd0 || ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid: out=%h busy=%b done=%b rdy=%b, want 00 0 0 1", ia.out, ia.busy, ia.done, ia.in_ready);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests++;
      if (ia.out !== 8'd0 || ia.busy !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_after[%0d]: out=%h busy=%b, want 00 0", c, ia.out, ia.busy);
      end
    end
    sbq.delete();
  endtask

  task automatic test_sweep();
    logic [7:0] want;
    int highs;
    for (int code = 0; code < 8; code++) begin
      highs = 0;
      want = 8'd0;
      ia.in_valid = 1'b1;
      ia.in = 3'(code);
      sbq.push_back(3'(code));
      for (int c = 0; c < 8; c++) begin
        tick();
        ia.in_valid = 1'b0;
        if (ia.out !== 8'd0 && want == 8'd0) want = 8'd1 << sbq.pop_front();
        if (ia.out !== 8'd0) begin
          highs++;
          tests++;
          if (ia.out !== want || $countones(ia.out) != 1) begin
            fails++;
            $display("FAIL sweep_code%0d[%0d]: out=%h want %h", code, c, ia.out, want);
          end
        end
      end
      tests++;
      if (highs != HOLD || want !== (8'd1 << code)) begin
        fails++;
        $display("FAIL sweep_width%0d: high=%0d line=%h, want %0d %h", code, highs, want, HOLD, 8'd1 << code);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ia.e = 1'b1; ia.in_valid = 1'b0; ia.in = 3'd0;
    ib.e = 1'b1; ib.in_valid = 1'b0; ib.in = 3'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap0();
    test_enable_abort();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
